waterfall_ctrl: RTL and testbench
=================================

Name: waterfall_ctrl

Overview:
Waterfall (running-light) LED pattern engine, directly downstream of the 50 MHz to 1 kHz divider.
- Samples the divider's 1 kHz square wave inside the 50 MHz domain and turns each rising edge into a one-cycle millisecond tick.
- Counts milliseconds to a selectable step period and advances one of four LED patterns on every step.
- Output drives the board LED bank.

Parameters:
LED_W, 8, number of LEDs; must be at least 2.
STEP_MS, 250, base step period in ms at speed=0; must be at least 4.
CNT_W, 10, millisecond counter width; must hold STEP_MS-1.

Ports:
clk  input  1  50 MHz system clock
rst_n  input  1  asynchronous active-low reset
clk_1khz  input  1  1 kHz square wave from the divider (same clock domain, treated as data)
run  input  1  1 = advance pattern, 0 = freeze
mode  input  2  0 rotate-left, 1 rotate-right, 2 ping-pong, 3 fill/clear
speed  input  2  step period = STEP_MS >> speed (floor, minimum 1)
led  output  LED_W  LED drive, 1 = lit unless WF_LED_INV_EN
dir  output  1  current direction: 0 = toward MSB / filling, 1 = toward LSB / clearing
step_pulse  output  1  one-cycle strobe coincident with each pattern update

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low on rst_n. All state clears on rst_n=0 regardless of clk.
- Reset values:
  - led = 1 (LSB lit); if mode=3 at reset release, it reloads to 0 under the mode-change rule below.
  - dir = 0; step_pulse = 0; ms_cnt = 0.
  - Sync/edge flops = 0; mode_q = 0.
- Tick generation:
  - clk_1khz passes through 2 flops (s1, s2) plus an edge flop s3.
  - ms_tick = s2 & ~s3.
  - Latency: 3 clk from the clk_1khz rise to ms_tick; exactly one tick per rising edge.
- Period: P = max(1, STEP_MS >> speed).
  - Speed changes apply immediately.
  - Compare uses ms_cnt >= P-1, so a shortened period steps on the next ms_tick.
- Counting: when run=1 and ms_tick:
  - If ms_cnt >= P-1: ms_cnt <= 0 and a step occurs.
  - Otherwise: ms_cnt increments.
  - When run=0: ms_cnt, led and dir hold, and step_pulse = 0.
  - Re-asserting run resumes from the held count.
- Step: led and dir update and step_pulse = 1 on the same clk edge (registered outputs).
- Mode change (mode != mode_q):
  - Next edge: mode_q <= mode, ms_cnt <= 0, dir <= 0, no step.
  - led reloads to the seed: 1 for modes 0–2, 0 for mode 3.
  - Mode reload has priority over a coincident step.
- Pattern rules per step:
  - Mode 0: led rotates left; the MSB wraps to the LSB. dir stays 0.
  - Mode 1: led rotates right; the LSB wraps to the MSB. dir stays 1 after the first step.
  - Mode 2, single lit bit bouncing:
    - dir=0: shift left. If led was at MSB-1 before the shift, dir <= 1.
    - dir=1: shift right. If led was at bit 1 before the shift, dir <= 0.
    - Sequence for LED_W=8: 01,02,…,80,40,…,01,02. No repeated end values.
  - Mode 3, fill/clear:
    - dir=0: led <= {led[LED_W-2:0],1}. On reaching all-ones, dir <= 1.
    - dir=1: led <= {led[LED_W-2:0],0}. On reaching zero, dir <= 0.
    - Cycle length 2*LED_W steps: 00,01,03,…,FF,FE,FC,…,00.
- Reset mid-operation: immediate return to reset values; the first step occurs P ms after release.
- No combinational path from inputs to outputs.

Optional Feature:
WF_LED_INV_EN
- Defined: led pins are driven with the bitwise inverse of the internal pattern, for boards with active-low LEDs. The reset pin value is then ~1. dir and step_pulse are unaffected.
- Undefined: led = internal pattern.

Test Plan:
Benches use STEP_MS=4 and drive clk_1khz with a 20-clk period.
- Reset/tick: rst_n low 5 clk then high; toggle clk_1khz → led=8'h01, dir=0 during reset; ms_tick fires 3 clk after each clk_1khz rise, once per rise.
- Rotate: mode=0, speed=0, run=1 → step_pulse every 4 ms ticks; led 01,02,04,…,80,01. Then mode=1 → next clk led=01, ms_cnt=0; following steps 80,40.
- Ping-pong: mode=2 for 16 steps → 01,02,04,08,10,20,40,80,40,20,10,08,04,02,01,02; dir goes 1 on the step to 80 and 0 on the step to 01.
- Fill/clear: mode=3 for 16 steps → 01,03,07,…,FF,FE,FC,…,80,00; dir toggles at FF and at 00.
- Speed/run: with ms_cnt=3, set speed=2 (P=1) → step on the next ms_tick, then on every tick. Drop run for 10 ticks → led and ms_cnt frozen, no step_pulse; re-assert → stepping resumes.
- Edge cases: mode change coincident with a step-tick → led reloads to the seed with no step_pulse. Assert rst_n mid-pattern, asynchronously between clk edges → outputs go to reset values before the next clk. Build with WF_LED_INV_EN → led=8'hFE after reset.

Source files
------------

// File: rtl/waterfall_ctrl_if.sv
// Waterfall controller bus: divider clock, run/mode/speed controls and LED-bank outputs.
// master = pattern consumer/driver of controls, slave = waterfall_ctrl itself.
interface waterfall_ctrl_if #(
    parameter int unsigned LED_W = 8
);
    logic             clk_1khz;
    logic             run;
    logic [1:0]       mode;
    logic [1:0]       speed;
    logic [LED_W-1:0] led;
    logic             dir;
    logic             step_pulse;

    modport master (
        output clk_1khz, run, mode, speed,
        input  led, dir, step_pulse
    );

    modport slave (
        input  clk_1khz, run, mode, speed,
        output led, dir, step_pulse
    );
endinterface

// File: rtl/waterfall_ctrl.sv
// Waterfall (running-light) LED pattern engine.
// Turns the 1 kHz divider output into millisecond ticks, counts ticks to a selectable step
// period and advances one of four patterns (rotate-left, rotate-right, ping-pong, fill/clear).
// Optional build macro WF_LED_INV_EN: drive the LED pins with the inverted pattern for
// active-low LED boards.
module waterfall_ctrl #(
    parameter int unsigned LED_W   = 8,
    parameter int unsigned STEP_MS = 250,
    parameter int unsigned CNT_W   = 10
) (
    input logic             clk,
    input logic             rst_n,
    waterfall_ctrl_if.slave bus
);

    typedef enum logic {
        DirUp   = 1'b0,
        DirDown = 1'b1
    } dir_e;

    // Step period for each speed setting, floored at one millisecond.
    localparam int unsigned P0 = (STEP_MS > 0) ? STEP_MS : 1;
    localparam int unsigned P1 = ((STEP_MS >> 1) > 0) ? (STEP_MS >> 1) : 1;
    localparam int unsigned P2 = ((STEP_MS >> 2) > 0) ? (STEP_MS >> 2) : 1;
    localparam int unsigned P3 = ((STEP_MS >> 3) > 0) ? (STEP_MS >> 3) : 1;

    localparam logic [CNT_W-1:0] LAST0 = CNT_W'(P0 - 1);
    localparam logic [CNT_W-1:0] LAST1 = CNT_W'(P1 - 1);
    localparam logic [CNT_W-1:0] LAST2 = CNT_W'(P2 - 1);
    localparam logic [CNT_W-1:0] LAST3 = CNT_W'(P3 - 1);

    localparam logic [LED_W-1:0] SEED_ONE  = LED_W'(1);
    localparam logic [LED_W-1:0] SEED_NONE = '0;

    logic             s1, s2, s3;
    logic             ms_tick;
    logic [CNT_W-1:0] period_last;
    logic             at_last;
    logic             mode_chg;

    logic [1:0]       mode_q;
    logic [CNT_W-1:0] ms_cnt;
    logic [LED_W-1:0] pat_q;
    dir_e             dir_q;
    logic             step_pulse_q;

    logic [LED_W-1:0] pat_nxt;
    dir_e             dir_nxt;
    logic [LED_W-1:0] fill_nxt;

    // Two-flop sampler plus edge flop on the 1 kHz square wave.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.clk_1khz;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign ms_tick = s2 & ~s3;

    // Last count value of the current step period; speed changes take effect at once.
    always_comb begin
        period_last = LAST0;
        unique case (bus.speed)
            2'd0: period_last = LAST0;
            2'd1: period_last = LAST1;
            2'd2: period_last = LAST2;
            2'd3: period_last = LAST3;
            default: period_last = LAST0;
        endcase
    end

    // ">=" lets a shortened period step on the very next tick.
    assign at_last  = (ms_cnt >= period_last);
    assign mode_chg = (bus.mode != mode_q);

    // Next pattern and direction if a step happens in the currently latched mode.
    always_comb begin
        pat_nxt  = pat_q;
        dir_nxt  = dir_q;
        fill_nxt = {pat_q[LED_W-2:0], (dir_q == DirUp)};
        unique case (mode_q)
            2'd0: begin
                pat_nxt = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
                dir_nxt = DirUp;
            end
            2'd1: begin
                pat_nxt = {pat_q[0], pat_q[LED_W-1:1]};
                dir_nxt = DirDown;
            end
            2'd2: begin
                // Turn around one position early so the end LEDs are not shown twice.
                if (dir_q == DirUp) begin
                    pat_nxt = pat_q << 1;
                    if (pat_q[LED_W-2]) dir_nxt = DirDown;
                end else begin
                    pat_nxt = pat_q >> 1;
                    if (pat_q[1]) dir_nxt = DirUp;
                end
            end
            2'd3: begin
                pat_nxt = fill_nxt;
                if ((dir_q == DirUp) && (&fill_nxt)) dir_nxt = DirDown;
                if ((dir_q == DirDown) && (fill_nxt == '0)) dir_nxt = DirUp;
            end
            default: begin
                pat_nxt = pat_q;
                dir_nxt = dir_q;
            end
        endcase
    end

    // Pattern engine state: mode reload wins over a coincident step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q       <= 2'd0;
            ms_cnt       <= '0;
            pat_q        <= SEED_ONE;
            dir_q        <= DirUp;
            step_pulse_q <= 1'b0;
        end else begin
            step_pulse_q <= 1'b0;
            if (mode_chg) begin
                mode_q <= bus.mode;
                ms_cnt <= '0;
                dir_q  <= DirUp;
                pat_q  <= (bus.mode == 2'd3) ? SEED_NONE : SEED_ONE;
            end else if (bus.run && ms_tick) begin
                if (at_last) begin
                    ms_cnt       <= '0;
                    pat_q        <= pat_nxt;
                    dir_q        <= dir_nxt;
                    step_pulse_q <= 1'b1;
                end else begin
                    ms_cnt <= ms_cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef WF_LED_INV_EN
    assign bus.led = ~pat_q;
`else
    assign bus.led = pat_q;
`endif
    assign bus.dir        = dir_q;
    assign bus.step_pulse = step_pulse_q;

endmodule

// File: tb/tb_waterfall_ctrl.sv
// Randomized bench for waterfall_ctrl against a step-index reference model.
// The model tracks only "steps since last reload" and derives LED/dir in closed form.
module tb_waterfall_ctrl;

    localparam int W    = 8;
    localparam int STEP = 4;
    localparam int CW   = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    waterfall_ctrl_if #(.LED_W(W)) bus ();

    waterfall_ctrl #(
        .LED_W  (W),
        .STEP_MS(STEP),
        .CNT_W  (CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [1:0] m_mode_q;
    int         m_cnt;
    int         m_k;
    logic       m_step;
    logic       h0, h1, h2;  // clk_1khz samples from the last three edges

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int period_of(input logic [1:0] spd);
        int p;
        p = STEP >> spd;
        if (p < 1) p = 1;
        return p;
    endfunction

    function automatic logic [W-1:0] exp_led(input logic [1:0] m, input int k);
        int p;
        int pos;
        case (m)
            2'd0: return W'(1 << (k % W));
            2'd1: return W'(1 << ((W - (k % W)) % W));
            2'd2: begin
                p   = k % (2 * W - 2);
                pos = (p < W) ? p : (2 * W - 2 - p);
                return W'(1 << pos);
            end
            default: begin
                p = k % (2 * W);
                if (p <= W) return W'((1 << p) - 1);
                return W'(((1 << W) - 1) << (p - W));
            end
        endcase
    endfunction

    function automatic logic exp_dir(input logic [1:0] m, input int k);
        case (m)
            2'd0: return 1'b0;
            2'd1: return (k > 0);
            2'd2: return ((k % (2 * W - 2)) >= W - 1);
            default: return ((k % (2 * W)) >= W);
        endcase
    endfunction

    task automatic model_reset();
        m_mode_q = 2'd0;
        m_cnt    = 0;
        m_k      = 0;
        m_step   = 1'b0;
        h0 = 1'b0;
        h1 = 1'b0;
        h2 = 1'b0;
    endtask

    // A clk_1khz rise seen at edge n-2 (not at n-3) is a millisecond tick acting at edge n.
    task automatic model_edge();
        logic tick;
        if (!rst_n) begin
            model_reset();
        end else begin
            tick   = h1 & ~h2;
            m_step = 1'b0;
            if (bus.mode != m_mode_q) begin
                m_mode_q = bus.mode;
                m_cnt    = 0;
                m_k      = 0;
            end else if (bus.run && tick) begin
                if (m_cnt >= period_of(bus.speed) - 1) begin
                    m_cnt  = 0;
                    m_k    = m_k + 1;
                    m_step = 1'b1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            h2 = h1;
            h1 = h0;
            h0 = bus.clk_1khz;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [W-1:0] led_e;
        led_e = exp_led(m_mode_q, m_k);
`ifdef WF_LED_INV_EN
        led_e = ~led_e;
`endif
        check({tag, "_led"}, 32'(bus.led), 32'(led_e));
        check({tag, "_dir"}, 32'(bus.dir), 32'(exp_dir(m_mode_q, m_k)));
        check({tag, "_step"}, 32'(bus.step_pulse), 32'(m_step));
    endtask

    initial begin
        int rst_hold;
        int coinc;
        logic imminent;

        rst_hold     = 0;
        coinc        = 0;
        bus.clk_1khz = 1'b0;
        bus.run      = 1'b1;
        bus.mode     = 2'($urandom_range(0, 3));
        bus.speed    = 2'd0;
        model_reset();

        // Held reset: outputs at reset values while clk_1khz keeps toggling.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.clk_1khz = ((i / 2) % 2) == 1;
            @(posedge clk);
            #1;
            check_outputs("reset");
        end

        for (int cyc = 0; cyc < 12000; cyc++) begin
            @(negedge clk);
            bus.clk_1khz = ((cyc / 10) % 2) == 1;
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst_n = 1'b1;
            end else begin
                rst_n = 1'b1;
                if ($urandom_range(0, 1499) == 0) bus.mode = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 699) == 0) bus.speed = 2'($urandom_range(0, 3));
                if (bus.run) begin
                    if ($urandom_range(0, 999) == 0) bus.run = 1'b0;
                end else begin
                    if ($urandom_range(0, 299) == 0) bus.run = 1'b1;
                end
                // Occasionally land a mode change exactly on a pending step.
                imminent = h1 && !h2 && bus.run && (bus.mode == m_mode_q) &&
                           (m_cnt >= period_of(bus.speed) - 1);
                if (imminent && cyc > 2000 && coinc < 4 && $urandom_range(0, 3) == 0) begin
                    bus.mode = bus.mode + 2'd1;
                    coinc++;
                end
            end

            @(posedge clk);
            model_edge();
            #1;
            check_outputs("run");

            // Asynchronous reset between clock edges.
            if (cyc == 4000 || cyc == 8500) begin
                #2;
                rst_n = 1'b0;
                #1;
                model_reset();
                check_outputs("async_rst");
                rst_hold = 3;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
